lap_stop_watch: RTL and testbench



---
 rtl/lap_stop_watch.sv | 184 ++++++++++++++++++
 tb/tb_lap_stop_watch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stop_watch.sv
// lap_stop_watch: seconds stopwatch with mode and lap push-buttons.
//
// Mode button cycles IDLE -> CLEAR -> RUNNING -> IDLE. While RUNNING a
// prescaler divides clk by TICKS_PER_SEC and time_o counts seconds. Lap
// presses while RUNNING push time_o into a small FIFO that a consumer
// drains with lap_rd_i.
//
// Ports:
//   clk          system clock, rising edge
//   rst_i        asynchronous active-high reset
//   button_i     raw mode button (asynchronous)
//   lap_i        raw lap button (asynchronous)
//   lap_rd_i     pop request, honoured only while lap_valid_o
//   mode_o       one-hot mode: IDLE=100, CLEAR=010, RUNNING=001
//   time_o       elapsed seconds
//   lap_valid_o  FIFO non-empty
//   lap_time_o   FIFO head entry, 0 when empty
//   lap_count_o  number of entries held
//   lap_ovf_o    sticky: a lap was dropped on a full FIFO
//
// Build option: define LAP_STOP_WATCH_SAT_EN to make time_o saturate at
// its maximum instead of wrapping to 0.

module lap_stop_watch #(
  parameter int TICKS_PER_SEC = 100,
  parameter int TIME_W        = 5,
  parameter int LAP_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic                           button_i,
  input  logic                           lap_i,
  input  logic                           lap_rd_i,
  output logic [2:0]                     mode_o,
  output logic [TIME_W-1:0]              time_o,
  output logic                           lap_valid_o,
  output logic [TIME_W-1:0]              lap_time_o,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count_o,
  output logic                           lap_ovf_o
);

  localparam int PRE_W  = $clog2(TICKS_PER_SEC);
  localparam int ADDR_W = $clog2(LAP_DEPTH);
  localparam int CNT_W  = $clog2(LAP_DEPTH+1);

  typedef enum logic [2:0] {
    IDLE    = 3'b100,
    CLEAR   = 3'b010,
    RUNNING = 3'b001
  } state_t;

  // ---------------- button conditioning ----------------
  // Bit 0 = mode button, bit 1 = lap button.
  logic [1:0] raw_btn;
  logic [1:0] pulse;
  logic [2:0] settle_reg;

  assign raw_btn = {lap_i, button_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic s1_reg, s2_reg, dly_reg;
      always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          dly_reg <= 1'b0;
        end else begin
          s1_reg  <= raw_btn[gi];
          s2_reg  <= s1_reg;
          dly_reg <= s2_reg;
        end
      end
      assign pulse[gi] = s2_reg & ~dly_reg;
    end
  endgenerate

  // The edge flops come out of reset at 0, so a button already held high
  // would look like a fresh rising edge once the pipeline fills. Pulses are
  // masked until the pipeline has been refilled from the live inputs.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) settle_reg <= 3'b000;
    else       settle_reg <= {settle_reg[1:0], 1'b1};
  end

  logic mode_pulse, lap_pulse;
  assign mode_pulse = pulse[0] & settle_reg[2];
  assign lap_pulse  = pulse[1] & settle_reg[2];

  // ---------------- mode FSM ----------------
  state_t state_reg, state_next;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mode_pulse) state_next = CLEAR;
      CLEAR:   if (mode_pulse) state_next = RUNNING;
      RUNNING: if (mode_pulse) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mode_o = state_reg;

  // ---------------- timer ----------------
  logic [PRE_W-1:0]  presc_reg;
  logic [TIME_W-1:0] time_reg;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      presc_reg <= '0;
      time_reg  <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          presc_reg <= '0;
          time_reg  <= '0;
        end
        RUNNING: begin
          if (presc_reg == PRE_W'(TICKS_PER_SEC-1)) begin
            presc_reg <= '0;
`ifdef LAP_STOP_WATCH_SAT_EN
            if (time_reg != '1) time_reg <= time_reg + TIME_W'(1);
`else
            time_reg <= time_reg + TIME_W'(1);
`endif
          end else begin
            presc_reg <= presc_reg + PRE_W'(1);
          end
        end
        default: ;  // IDLE: frozen
      endcase
    end
  end

  assign time_o = time_reg;

  // ---------------- lap FIFO ----------------
  logic [TIME_W-1:0] lap_mem [LAP_DEPTH];
  logic [ADDR_W:0]   wr_ptr_reg, rd_ptr_reg, fill;
  logic              ovf_reg, empty, full, push, pop, wr_en;

  assign fill  = wr_ptr_reg - rd_ptr_reg;
  assign empty = (fill == '0);
  assign full  = (fill == (ADDR_W+1)'(LAP_DEPTH));
  // The lap sees time_reg before any increment on the same edge.
  assign push  = lap_pulse && (state_reg == RUNNING);
  assign pop   = lap_rd_i && !empty;
  // On a full FIFO a same-cycle pop frees the slot being written.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else if (state_reg == CLEAR) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (ADDR_W+1)'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + (ADDR_W+1)'(1);
      if (push && full && !pop) ovf_reg <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) lap_mem[wr_ptr_reg[ADDR_W-1:0]] <= time_reg;
  end

  assign lap_valid_o = !empty;
  assign lap_time_o  = empty ? '0 : lap_mem[rd_ptr_reg[ADDR_W-1:0]];
  assign lap_count_o = CNT_W'(fill);
  assign lap_ovf_o   = ovf_reg;

endmodule

// File: tb/tb_lap_stop_watch.sv
// Directed bench for lap_stop_watch with a lap scoreboard queue.
module tb_lap_stop_watch;

  localparam int TPS = 100;
  localparam int TW  = 5;
  localparam int LD  = 4;

  logic          tb_clk = 1'b0;
  logic          rst_i, button_i, lap_i, lap_rd_i;
  logic [2:0]    mode_o;
  logic [TW-1:0] time_o, lap_time_o;
  logic          lap_valid_o, lap_ovf_o;
  logic [2:0]    lap_count_o;

  int total = 0;
  int bad   = 0;
  int sb[$];

  lap_stop_watch #(.TICKS_PER_SEC(TPS), .TIME_W(TW), .LAP_DEPTH(LD)) dut (
    .clk(tb_clk), .rst_i(rst_i), .button_i(button_i), .lap_i(lap_i),
    .lap_rd_i(lap_rd_i), .mode_o(mode_o), .time_o(time_o),
    .lap_valid_o(lap_valid_o), .lap_time_o(lap_time_o),
    .lap_count_o(lap_count_o), .lap_ovf_o(lap_ovf_o)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) $display("ok   %s observed=%0d expected=%0d", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mode press: pulse acts on the 3rd edge after the press; returns at a negedge.
  task automatic press_mode();
    @(negedge tb_clk) button_i = 1'b1;
    repeat (4) @(negedge tb_clk);
    button_i = 1'b0;
    repeat (3) @(negedge tb_clk);
  endtask

  task automatic lap_press();
    @(negedge tb_clk) lap_i = 1'b1;
    repeat (3) @(negedge tb_clk);
    lap_i = 1'b0;
    repeat (3) @(negedge tb_clk);
  endtask

  // Lap press with lap_rd_i asserted exactly on the capture edge.
  task automatic lap_press_pop();
    @(negedge tb_clk) lap_i = 1'b1;
    @(negedge tb_clk);
    @(negedge tb_clk) lap_rd_i = 1'b1;
    @(negedge tb_clk) lap_rd_i = 1'b0;
    lap_i = 1'b0;
    repeat (3) @(negedge tb_clk);
  endtask

  task automatic wait_time(input int k);
    int n = 0;
    while (time_o !== TW'(k) && n < 1000) begin
      @(negedge tb_clk);
      n++;
    end
    check($sformatf("reach_time_%0d", k), (n < 1000), 1);
  endtask

  task automatic pop_check(input string tag);
    int e;
    e = sb.pop_front();
    check({tag, "_valid"}, lap_valid_o, 1);
    check({tag, "_data"}, lap_time_o, e);
    lap_rd_i = 1'b1;
    @(negedge tb_clk) lap_rd_i = 1'b0;
  endtask

  logic [2:0] held_exp [3];
  int         popped;
  int         wrap_exp;

  initial begin
    held_exp = '{3'b001, 3'b100, 3'b010};
    rst_i = 1'b1; button_i = 1'b1; lap_i = 1'b0; lap_rd_i = 1'b0;

    // Reset with the mode button held
    repeat (3) @(negedge tb_clk);
    check("rst_mode", mode_o, 3'b100);
    check("rst_time", time_o, 0);
    check("rst_valid", lap_valid_o, 0);
    check("rst_count", lap_count_o, 0);
    check("rst_ovf", lap_ovf_o, 0);
    check("rst_laptime", lap_time_o, 0);
    rst_i = 1'b0;
    repeat (10) @(negedge tb_clk);
    check("held_no_edge_mode", mode_o, 3'b100);
    check("held_no_edge_time", time_o, 0);

    // Press latency: visible on the 3rd rising edge
    button_i = 1'b0;
    repeat (4) @(negedge tb_clk);
    button_i = 1'b1;
    @(posedge tb_clk) #1 check("edge1", mode_o, 3'b100);
    @(posedge tb_clk) #1 check("edge2", mode_o, 3'b100);
    @(posedge tb_clk) #1 check("edge3", mode_o, 3'b010);
    repeat (20) @(negedge tb_clk);
    button_i = 1'b0;
    repeat (3) @(negedge tb_clk);

    // Long presses: one step each
    for (int i = 0; i < 3; i++) begin
      @(negedge tb_clk) button_i = 1'b1;
      repeat (20) @(negedge tb_clk);
      check($sformatf("held_press_%0d", i), mode_o, held_exp[i]);
      button_i = 1'b0;
      repeat (3) @(negedge tb_clk);
    end

    // 300 RUNNING edges -> 3 s, frozen in IDLE
    press_mode();
    check("run_mode", mode_o, 3'b001);
    repeat (292) @(negedge tb_clk);
    press_mode();
    check("stop_mode", mode_o, 3'b100);
    check("time_300", time_o, 3);
    repeat (50) @(negedge tb_clk);
    check("time_idle_frozen", time_o, 3);
    lap_press();
    check("idle_lap_ignored", lap_count_o, 0);
    lap_rd_i = 1'b1;
    @(negedge tb_clk) lap_rd_i = 1'b0;
    check("empty_pop_count", lap_count_o, 0);
    check("empty_pop_valid", lap_valid_o, 0);
    press_mode();
    check("clear_mode", mode_o, 3'b010);
    check("clear_time", time_o, 0);

    // Laps at 1, 2, 3
    press_mode();
    for (int k = 1; k <= 3; k++) begin
      wait_time(k);
      lap_press();
      sb.push_back(k);
    end
    check("laps_count", lap_count_o, 3);
    check("laps_head", lap_time_o, 1);
    for (int i = 0; i < 3; i++) pop_check($sformatf("pop%0d", i));
    check("drained_valid", lap_valid_o, 0);
    check("drained_laptime", lap_time_o, 0);
    check("drained_count", lap_count_o, 0);

    // Overflow: five laps, last one dropped
    for (int k = 4; k <= 8; k++) begin
      wait_time(k);
      lap_press();
      if (sb.size() < LD) sb.push_back(k);
    end
    check("ovf_count", lap_count_o, 4);
    check("ovf_flag", lap_ovf_o, 1);
    check("ovf_head", lap_time_o, sb[0]);
    press_mode();
    press_mode();
    check("flush_mode", mode_o, 3'b010);
    check("flush_count", lap_count_o, 0);
    check("flush_ovf", lap_ovf_o, 0);
    check("flush_valid", lap_valid_o, 0);
    sb.delete();

    // Push and pop together while full
    press_mode();
    for (int k = 1; k <= 4; k++) begin
      wait_time(k);
      lap_press();
      sb.push_back(k);
    end
    wait_time(5);
    check("full_before_count", lap_count_o, 4);
    check("full_before_head", lap_time_o, sb[0]);
    lap_press_pop();
    popped = sb.pop_front();
    sb.push_back(5);
    check("pushpop_count", lap_count_o, 4);
    check("pushpop_ovf", lap_ovf_o, 0);
    check("pushpop_head", lap_time_o, sb[0]);
    check("pushpop_popped_was_first", popped, 1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("pp_pop%0d", i));
    check("pp_drained", lap_valid_o, 0);

    // 3300 RUNNING edges: wrap or saturate
    press_mode();
    press_mode();
    press_mode();
    check("wrap_run_mode", mode_o, 3'b001);
    repeat (3292) @(negedge tb_clk);
    press_mode();
`ifdef LAP_STOP_WATCH_SAT_EN
    wrap_exp = 31;
`else
    wrap_exp = 1;
`endif
    check("wrap_time", time_o, wrap_exp);

    // Asynchronous reset mid-operation, no clock edge
    press_mode();
    press_mode();
    wait_time(2);
    lap_press();
    check("pre_async_count", lap_count_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_mode", mode_o, 3'b100);
    check("async_time", time_o, 0);
    check("async_count", lap_count_o, 0);
    check("async_valid", lap_valid_o, 0);
    @(negedge tb_clk) rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
